ring_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one resource among N requesters.

---
 rtl/ring_arb_pkg.sv | 34 +++
 rtl/ring_ptr.sv | 46 ++++
 rtl/ring_rr_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_ring_rr_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ring_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ring_arb_pkg
//  Description : Shared types and helpers for the ring round-robin arbiter.
//                - arb_state_t : two-state arbiter FSM encoding
//                - onehot2bin  : one-hot (up to 64 bits) to binary index
//  Revision    : 1.0  initial release
// ============================================================================
package ring_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of the index produced by onehot2bin; callers cast down to the
    // width they need.
    localparam int c_OH2B_W = 6;

    // OR-reduction encoder: for a legal one-hot input exactly one index is
    // OR-ed in; a zero input yields index 0.
    function automatic logic [c_OH2B_W-1:0] onehot2bin(input logic [63:0] onehot);
        logic [c_OH2B_W-1:0] bin;
        bin = '0;
        for (int i = 0; i < 64; i++) begin
            if (onehot[i]) begin
                bin = bin | c_OH2B_W'(i);
            end
        end
        return bin;
    endfunction

endpackage : ring_arb_pkg
`default_nettype wire

// File: rtl/ring_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : ring_ptr
//  Description : One-hot rotating priority pointer (ring counter).
//                advance only        : ptr <= rotl(ptr)
//                load only           : ptr <= load_val
//                load and advance    : ptr <= rotl(load_val)
//                reset (sync, high)  : ptr <= 1 (bit 0)
//  Ports       : clk, reset       clock / synchronous active-high reset
//                advance          rotate-left enable
//                load, load_val   load from a one-hot value
//                ptr              current one-hot pointer
//  Revision    : 1.0  initial release
// ============================================================================
module ring_ptr #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         advance,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] ptr
);

    logic [N-1:0] r_ptr;
    logic [N-1:0] w_base;
    logic [N-1:0] w_next;

    always_comb begin
        w_base = load ? load_val : r_ptr;
        w_next = advance ? {w_base[N-2:0], w_base[N-1]} : w_base;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= N'(1);
        end else begin
            r_ptr <= w_next;
        end
    end

    assign ptr = r_ptr;

endmodule : ring_ptr
`default_nettype wire

// File: rtl/ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ring_rr_arbiter
//  Description : Round-robin arbiter sharing one resource among N requesters.
//                Priority starts at a one-hot ring pointer and searches
//                cyclically upward. A grant is held until the owner asserts
//                done, drops its request, or the hold limit expires (forced
//                release, flagged by a one-cycle timeout pulse). Every release
//                is followed by one idle cycle and moves the pointer just past
//                the released owner.
//  Ports       : clk, reset    clock / synchronous active-high reset
//                req[N]        level requests
//                done          owner release (only looked at while granted)
//                grant[N]      registered one-hot grant
//                grant_valid   registered |grant
//                grant_idx     registered binary index of the owner (0 if none)
//                timeout       one-cycle pulse after a forced release
//  Revision    : 1.0  initial release
// ============================================================================
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 timeout
);

    localparam int c_IDX_W  = $clog2(N);
    // A zero-width counter is not legal; with no timeout a 1-bit saturating
    // counter is kept and simply never compared.
    localparam int c_HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(MAX_HOLD - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = {c_HOLD_W{1'b1}};

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [N-1:0]          r_grant;
    logic [N-1:0]          w_grant_nxt;
    logic                  r_grant_valid;
    logic                  w_valid_nxt;
    logic [c_IDX_W-1:0]    r_grant_idx;
    logic [c_IDX_W-1:0]    w_idx_nxt;
    logic                  r_timeout;
    logic                  w_timeout_nxt;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic [c_HOLD_W-1:0]   w_hold_nxt;

    logic [N-1:0]          w_ptr;
    logic                  w_ptr_move;
    logic [N-1:0]          w_mask;
    logic [N-1:0]          w_req_hi;
    logic [N-1:0]          w_pick;
    logic [N-1:0]          w_win;
    logic                  w_owner_req;
    logic                  w_normal_rel;
    logic                  w_limit_rel;

    // ------------------------------------------------------------------------
    // Pointer: on release it is loaded with the owner and rotated one step,
    // so the next search starts just after the previous winner.
    // ------------------------------------------------------------------------
    ring_ptr #(
        .N (N)
    ) u_ptr (
        .clk      (clk),
        .reset    (reset),
        .advance  (w_ptr_move),
        .load     (w_ptr_move),
        .load_val (r_grant),
        .ptr      (w_ptr)
    );

    // ------------------------------------------------------------------------
    // Masked priority search. ~(ptr-1) keeps bits at and above the pointer;
    // if none of those request, the search wraps to the full request vector.
    // x & (~x + 1) isolates the lowest set bit.
    // ------------------------------------------------------------------------
    always_comb begin
        w_mask   = ~(w_ptr - N'(1));
        w_req_hi = req & w_mask;
        w_pick   = (|w_req_hi) ? w_req_hi : req;
        w_win    = w_pick & (~w_pick + N'(1));
    end

    // ------------------------------------------------------------------------
    // Release conditions while granted. A done or request drop is a normal
    // release and suppresses the timeout pulse even if the limit coincides.
    // ------------------------------------------------------------------------
    always_comb begin
        w_owner_req  = |(req & r_grant);
        w_normal_rel = done | ~w_owner_req;
        w_limit_rel  = (MAX_HOLD > 0) && (r_hold_cnt == c_HOLD_LAST);
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_timeout     <= 1'b0;
            r_hold_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= w_valid_nxt;
            r_grant_idx   <= w_idx_nxt;
            r_timeout     <= w_timeout_nxt;
            r_hold_cnt    <= w_hold_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and next registered outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_valid_nxt   = r_grant_valid;
        w_idx_nxt     = r_grant_idx;
        w_timeout_nxt = 1'b0;
        w_hold_nxt    = r_hold_cnt;
        w_ptr_move    = 1'b0;

        case (r_state)
            IDLE: begin
                w_hold_nxt = '0;
                if (|req) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = w_win;
                    w_valid_nxt = 1'b1;
                    w_idx_nxt   = c_IDX_W'(onehot2bin(64'(w_win)));
                end else begin
                    w_grant_nxt = '0;
                    w_valid_nxt = 1'b0;
                    w_idx_nxt   = '0;
                end
            end

            GRANT: begin
                if (w_normal_rel || w_limit_rel) begin
                    w_state_nxt   = IDLE;
                    w_grant_nxt   = '0;
                    w_valid_nxt   = 1'b0;
                    w_idx_nxt     = '0;
                    w_hold_nxt    = '0;
                    w_timeout_nxt = ~w_normal_rel;
                    w_ptr_move    = 1'b1;
                end else if (r_hold_cnt != c_HOLD_MAX) begin
                    w_hold_nxt = r_hold_cnt + c_HOLD_W'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
                w_idx_nxt   = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;
    assign timeout     = r_timeout;

endmodule : ring_rr_arbiter
`default_nettype wire

// File: tb/tb_ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_rr_arbiter
//  Description : Directed, table-driven bench for ring_rr_arbiter (N=4,
//                MAX_HOLD=8, 10 ns clock). Each table row gives the inputs for
//                one rising edge and the registered outputs expected after it.
//                Timeout and limit-coincident release are exercised by short
//                hand-written loops.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ring_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       timeout;

    int n_tests;
    int n_fail;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] e_grant;
        logic       e_valid;
        logic [1:0] e_idx;
        logic       e_to;
    } vec_t;

    vec_t vecs[$];

    ring_rr_arbiter #(
        .N        (4),
        .MAX_HOLD (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] q, input logic d,
                       input logic [3:0] eg, input logic ev, input logic [1:0] ei,
                       input logic et);
        vec_t v;
        v.rst = r; v.req = q; v.done = d;
        v.e_grant = eg; v.e_valid = ev; v.e_idx = ei; v.e_to = et;
        vecs.push_back(v);
    endtask

    // Drive inputs, take one rising edge, sample 1 ns later and compare.
    task automatic step_check(input string name, input logic r, input logic [3:0] q,
                              input logic d, input logic [3:0] eg, input logic ev,
                              input logic [1:0] ei, input logic et);
        reset = r;
        req   = q;
        done  = d;
        @(posedge clk);
        #1;
        n_tests++;
        if (grant !== eg || grant_valid !== ev || grant_idx !== ei || timeout !== et) begin
            n_fail++;
            $display("FAIL %s: got grant=%b valid=%b idx=%0d timeout=%b, expected grant=%b valid=%b idx=%0d timeout=%b",
                     name, grant, grant_valid, grant_idx, timeout, eg, ev, ei, et);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        req     = 4'b0000;
        done    = 1'b0;

        //   rst  req      done  grant    vld  idx  to
        // Reset held two cycles with all requests high.
        add(1, 4'b1111, 0, 4'b0000, 0, 2'd0, 0);
        add(1, 4'b1111, 0, 4'b0000, 0, 2'd0, 0);
        add(0, 4'b1111, 0, 4'b0001, 1, 2'd0, 0);
        // Full rotation with a done pulse per grant, bubble after each.
        add(0, 4'b1111, 1, 4'b0000, 0, 2'd0, 0);
        add(0, 4'b1111, 0, 4'b0010, 1, 2'd1, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 2'd0, 0);
        add(0, 4'b1111, 0, 4'b0100, 1, 2'd2, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 2'd0, 0);
        add(0, 4'b1111, 0, 4'b1000, 1, 2'd3, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 2'd0, 0);
        add(0, 4'b1111, 0, 4'b0001, 1, 2'd0, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 2'd0, 0);   // ptr -> 0010
        // done while idle is ignored, pointer stays.
        add(0, 4'b0000, 1, 4'b0000, 0, 2'd0, 0);
        // Owner drops request: 1001 from ptr 0010 picks bit3.
        add(0, 4'b1001, 0, 4'b1000, 1, 2'd3, 0);
        add(0, 4'b0001, 0, 4'b0000, 0, 2'd0, 0);   // ptr -> 0001 (wrap)
        add(0, 4'b0001, 0, 4'b0001, 1, 2'd0, 0);
        // Non-owner request changes do not disturb the grant.
        add(0, 4'b0111, 0, 4'b0001, 1, 2'd0, 0);
        add(0, 4'b0011, 0, 4'b0001, 1, 2'd0, 0);
        add(0, 4'b0011, 1, 4'b0000, 0, 2'd0, 0);   // ptr -> 0010
        add(0, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
        // Reset mid-grant, then re-arbitrate from ptr 0001.
        add(0, 4'b0100, 0, 4'b0100, 1, 2'd2, 0);
        add(1, 4'b0110, 0, 4'b0000, 0, 2'd0, 0);
        add(0, 4'b0110, 0, 4'b0010, 1, 2'd1, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);   // req drop, ptr -> 0100

        for (int i = 0; i < vecs.size(); i++) begin
            step_check($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].done,
                       vecs[i].e_grant, vecs[i].e_valid, vecs[i].e_idx, vecs[i].e_to);
        end

        // Forced release: sole requester 0100 never signals done. Eight held
        // cycles, then a timeout cycle with grant=0, then an immediate regrant
        // because ptr=1000 wraps around to bit 2.
        for (int c = 0; c < 8; c++) begin
            step_check($sformatf("hold%0d", c), 0, 4'b0100, 0, 4'b0100, 1, 2'd2, 0);
        end
        step_check("timeout_pulse", 0, 4'b0100, 0, 4'b0000, 0, 2'd0, 1);
        step_check("regrant_after_timeout", 0, 4'b0100, 0, 4'b0100, 1, 2'd2, 0);
        step_check("release_after_regrant", 0, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);

        // done coinciding with the hold limit: normal release, no pulse.
        // ptr is 1000 here, so req 0010 wins by wrapping.
        for (int c = 0; c < 8; c++) begin
            step_check($sformatf("hold2_%0d", c), 0, 4'b0010, 0, 4'b0010, 1, 2'd1, 0);
        end
        step_check("done_at_limit", 0, 4'b0010, 1, 4'b0000, 0, 2'd0, 0);
        step_check("no_late_pulse", 0, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus process is ever stalled.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1);
    end

endmodule : tb_ring_rr_arbiter
`default_nettype wire
